// File: rtl/poker_pkg.sv
// Shared state encoding, hand codes and payout table for the poker round controller.
package poker_pkg;

   localparam int          W_WIN   = 10;
   localparam int unsigned N_SLOTS = 5;

   typedef enum logic [2:0] {
      ST_IDLE, ST_DEAL, ST_HOLD, ST_DRAW, ST_JUDGE, ST_CAPT, ST_OFFER, ST_PAY
   } round_state_t;

   typedef struct packed {
      logic [3:0] num;
      logic [2:0] suit;
   } card_t;

   localparam logic [3:0] HAND_NONE     = 4'd0;
   localparam logic [3:0] HAND_JACKS    = 4'd1;
   localparam logic [3:0] HAND_TWO_PAIR = 4'd2;
   localparam logic [3:0] HAND_THREE    = 4'd3;
   localparam logic [3:0] HAND_STRAIGHT = 4'd4;
   localparam logic [3:0] HAND_FLUSH    = 4'd5;
   localparam logic [3:0] HAND_FULL     = 4'd6;
   localparam logic [3:0] HAND_FOUR     = 4'd7;
   localparam logic [3:0] HAND_SF       = 4'd8;
   localparam logic [3:0] HAND_RSF      = 4'd10;
   localparam logic [3:0] HAND_INV      = 4'hF;

   function automatic logic [5:0] hand_mult(input logic [3:0] h);
      case (h)
         HAND_JACKS:    return 6'd1;
         HAND_TWO_PAIR: return 6'd2;
         HAND_THREE:    return 6'd3;
         HAND_STRAIGHT: return 6'd4;
         HAND_FLUSH:    return 6'd5;
         HAND_FULL:     return 6'd7;
         HAND_FOUR:     return 6'd10;
         HAND_SF:       return 6'd20;
         HAND_RSF:      return 6'd50;
         default:       return 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/poker_round_ctrl_if.sv
// Card-source handshake and hand-judge bus between the round controller and its neighbours.
interface poker_round_ctrl_if;
   logic       card_req;
   logic       card_ack;
   logic [3:0] card_num;
   logic [2:0] card_suit;
   logic [3:0] nnum0, nnum1, nnum2, nnum3, nnum4;
   logic [2:0] nsuit0, nsuit1, nsuit2, nsuit3, nsuit4;
   logic       pjudge;
   logic [3:0] hand_r;
   logic       dchance1;

   modport master (
      output card_req, nnum0, nnum1, nnum2, nnum3, nnum4,
             nsuit0, nsuit1, nsuit2, nsuit3, nsuit4, pjudge,
      input  card_ack, card_num, card_suit, hand_r, dchance1
   );

   modport slave (
      input  card_req, nnum0, nnum1, nnum2, nnum3, nnum4,
             nsuit0, nsuit1, nsuit2, nsuit3, nsuit4, pjudge,
      output card_ack, card_num, card_suit, hand_r, dchance1
   );
endinterface

// File: rtl/card_slot_fill.sv
// Five-slot hand store: fills the lowest unfilled slot on each accepted ack.
// DUPLICATE_REJECT_EN: discard acked cards already seen this round.
module card_slot_fill
   import poker_pkg::*;
(
   input  logic       clock,
   input  logic       reset_c,
   input  logic       fill_en,
   input  logic       clr_deal,
   input  logic       arm_draw,
   input  logic [4:0] keep_mask,
   input  logic       card_ack,
   input  card_t      card_in,
   output logic       card_req,
   output logic       fill_done,
   output card_t      slot [N_SLOTS]
);

   logic [4:0] filled;
   logic [2:0] next_idx;
   logic       found;
   logic       dup;
   logic       take;
   logic [4:0] take_1h;

   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (!filled[i] && !found) begin
            next_idx = 3'(i);
            found    = 1'b1;
         end
      end
   end

`ifdef DUPLICATE_REJECT_EN
   card_t dealt [N_SLOTS];
   logic  drawing;

   // During the redraw the original deal still counts, even for slots being replaced.
   always_comb begin
      dup = 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if ((filled[i] && slot[i] == card_in) || (drawing && dealt[i] == card_in))
            dup = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset_c) begin
         drawing <= 1'b0;
         dealt   <= '{default: '0};
      end else begin
         if (clr_deal)
            drawing <= 1'b0;
         else if (arm_draw)
            drawing <= 1'b1;
         if (take && !drawing)
            dealt[next_idx] <= card_in;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign card_req  = fill_en && !(&filled);
   assign take      = card_req && card_ack && !dup;
   assign take_1h   = take ? (5'b00001 << next_idx) : '0;
   assign fill_done = &(filled | take_1h);

   always_ff @(posedge clock) begin
      if (reset_c) begin
         filled <= '0;
         slot   <= '{default: '0};
      end else begin
         if (clr_deal)
            filled <= '0;
         else if (arm_draw)
            filled <= keep_mask;
         else if (take)
            filled <= filled | take_1h;
         if (take)
            slot[next_idx] <= card_in;
      end
   end

endmodule

// File: rtl/poker_round_ctrl.sv
// Poker round sequencer: bet, deal, hold, redraw, judge, then pay out or offer double-up.
// DUPLICATE_REJECT_EN (in card_slot_fill) enables duplicate-card rejection.
module poker_round_ctrl
   import poker_pkg::*;
#(
   parameter int CREDIT_W    = 16,
   parameter int INIT_CREDIT = 100,
   parameter int BET_MAX     = 10
) (
   input  logic                clock,
   input  logic                reset_c,
   input  logic                start,
   input  logic [3:0]          bet,
   input  logic [4:0]          hold_btn,
   input  logic                confirm,
   input  logic                dbl_take,
   input  logic                dbl_skip,
   poker_round_ctrl_if.master  cbus,
   output logic                dbl_go,
   output logic [W_WIN-1:0]    dbl_amt,
   output logic [4:0]          hold_mask,
   output logic [3:0]          hand_code,
   output logic [W_WIN-1:0]    win,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                err
);

   localparam logic [3:0] BET_MAX_L = 4'(BET_MAX);

   round_state_t        state, state_n;
   logic [3:0]          bet_r;
   logic                bet_ok;
   logic                fill_en, clr_deal, arm_draw, fill_done;
   logic [W_WIN-1:0]    win_calc;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_sat;
   card_t               slot [N_SLOTS];

   assign bet_ok     = (bet != '0) && (bet <= BET_MAX_L) && (CREDIT_W'(bet) <= credit);
   assign win_calc   = W_WIN'(bet_r) * W_WIN'(hand_mult(cbus.hand_r));
   assign credit_sum = {1'b0, credit} + (CREDIT_W + 1)'(win);
   assign credit_sat = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];

   card_slot_fill u_fill (
      .clock     (clock),
      .reset_c   (reset_c),
      .fill_en   (fill_en),
      .clr_deal  (clr_deal),
      .arm_draw  (arm_draw),
      .keep_mask (hold_mask ^ hold_btn),
      .card_ack  (cbus.card_ack),
      .card_in   ({cbus.card_num, cbus.card_suit}),
      .card_req  (cbus.card_req),
      .fill_done (fill_done),
      .slot      (slot)
   );

   assign {cbus.nnum0, cbus.nsuit0} = slot[0];
   assign {cbus.nnum1, cbus.nsuit1} = slot[1];
   assign {cbus.nnum2, cbus.nsuit2} = slot[2];
   assign {cbus.nnum3, cbus.nsuit3} = slot[3];
   assign {cbus.nnum4, cbus.nsuit4} = slot[4];

   assign cbus.pjudge = (state == ST_JUDGE);
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset_c)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      fill_en  = 1'b0;
      clr_deal = 1'b0;
      arm_draw = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && bet_ok) begin
               clr_deal = 1'b1;
               state_n  = ST_DEAL;
            end
         end
         ST_DEAL: begin
            fill_en = 1'b1;
            if (fill_done) state_n = ST_HOLD;
         end
         ST_HOLD: begin
            if (confirm) begin
               arm_draw = 1'b1;
               state_n  = ST_DRAW;
            end
         end
         ST_DRAW: begin
            fill_en = 1'b1;
            if (fill_done) state_n = ST_JUDGE;
         end
         ST_JUDGE: state_n = ST_CAPT;
         ST_CAPT: begin
            if (cbus.hand_r != HAND_INV && cbus.dchance1 && win_calc != '0)
               state_n = ST_OFFER;
            else
               state_n = ST_PAY;
         end
         ST_OFFER: begin
            if (dbl_take)
               state_n = ST_IDLE;
            else if (dbl_skip)
               state_n = ST_PAY;
         end
         ST_PAY:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_c) begin
         credit    <= CREDIT_W'(INIT_CREDIT);
         bet_r     <= '0;
         hold_mask <= '0;
         hand_code <= '0;
         win       <= '0;
         dbl_amt   <= '0;
         dbl_go    <= 1'b0;
         err       <= 1'b0;
      end else begin
         err    <= 1'b0;
         dbl_go <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (bet_ok) begin
                     credit    <= credit - CREDIT_W'(bet);
                     bet_r     <= bet;
                     hold_mask <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_HOLD: hold_mask <= hold_mask ^ hold_btn;
            ST_CAPT: begin
               if (cbus.hand_r == HAND_INV) begin
                  hand_code <= '0;
                  win       <= '0;
                  err       <= 1'b1;
               end else begin
                  hand_code <= cbus.hand_r;
                  win       <= win_calc;
               end
            end
            ST_OFFER: begin
               if (dbl_take) begin
                  dbl_go  <= 1'b1;
                  dbl_amt <= win;
               end
            end
            ST_PAY:  credit <= credit_sat;
            default: ;
         endcase
      end
   end

endmodule
